// File: rtl/rock_spawner.sv
// rock_spawner: frame-timed spawn scheduler for the rock pool.
// Picks a free slot round-robin, derives an edge position and inward direction
// from an LFSR, pulses the slot's start and confirms activation. Also turns
// hit flags and clear_all into one-cycle rock_reset pulses.
module rock_spawner #(
  parameter int unsigned NUM_ROCKS    = 8,
  parameter int unsigned SPAWN_PERIOD = 120,
  parameter int unsigned SCREEN_W     = 640,
  parameter int unsigned SCREEN_H     = 480,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                 clk60hz,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear_all,
  input  logic [NUM_ROCKS-1:0] in_use,
  input  logic [NUM_ROCKS-1:0] hit,
  output logic [NUM_ROCKS-1:0] start,
  output logic [NUM_ROCKS-1:0] rock_reset,
  output logic [9:0]           init_x,
  output logic [9:0]           init_y,
  output logic [2:0]           dir_x,
  output logic [2:0]           dir_y,
  output logic [7:0]           spawn_count,
  output logic                 spawn_fail
);

  localparam int unsigned PW = $clog2(NUM_ROCKS);
  localparam int unsigned TW = $clog2(SPAWN_PERIOD);
  localparam logic [TW-1:0] RELOAD = TW'(SPAWN_PERIOD - 1);
  localparam logic [PW-1:0] LAST_SLOT = PW'(NUM_ROCKS - 1);
  localparam logic [9:0] X_MAX = 10'(SCREEN_W - 1);
  localparam logic [9:0] Y_MAX = 10'(SCREEN_H - 1);

  typedef enum logic [1:0] {IDLE, PICK, LAUNCH, CONFIRM} state_t;

  state_t              state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                pending_q, pending_d;
  logic [PW-1:0]       rr_q, rr_d;
  logic [PW-1:0]       slot_q, slot_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [9:0]          ix_q, ix_d, iy_q, iy_d;
  logic [2:0]          dx_q, dx_d, dy_q, dy_d;
  logic [7:0]          count_q, count_d;
  logic                fail_q, fail_d;
  logic [NUM_ROCKS-1:0] rst_q, rst_d;

  logic                tick;
  logic                found;
  logic [PW-1:0]       pick, idx;
  logic [9:0]          r, rx, ry, gx, gy;
  logic [1:0]          edge_sel, spx, spy, spx_nz, spy_nz;
  logic [2:0]          gdx, gdy;

  // Frame timer: counts down while enabled, ticks on reaching zero.
  always_comb begin
    tick    = enable && (timer_q == '0);
    timer_d = timer_q;
    if (clear_all)     timer_d = RELOAD;
    else if (enable)   timer_d = (timer_q == '0) ? RELOAD : timer_q - TW'(1);
    lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // Round-robin search for the first free slot starting at rr_q.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_ROCKS; i++) begin
      idx = PW'((32'(rr_q) + i) % NUM_ROCKS);
      if (!found && !in_use[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Spawn geometry from the current LFSR value.
  always_comb begin
    edge_sel = lfsr_q[1:0];
    r        = lfsr_q[11:2];
    rx       = (32'(r) >= SCREEN_W) ? r - 10'd512 : r;
    ry       = (32'(r) >= SCREEN_H) ? r - 10'd512 : r;
    spx      = lfsr_q[14:13];
    spy      = {lfsr_q[15], lfsr_q[0]};
    spx_nz   = (spx == 2'd0) ? 2'd1 : spx;
    spy_nz   = (spy == 2'd0) ? 2'd1 : spy;
    gx       = rx;
    gy       = '0;
    gdx      = {lfsr_q[12], spx};
    gdy      = {1'b0, spy_nz};
    case (edge_sel)
      2'd0: begin gx = rx;    gy = '0;    gdx = {lfsr_q[12], spx}; gdy = {1'b0, spy_nz};     end
      2'd1: begin gx = rx;    gy = Y_MAX; gdx = {lfsr_q[12], spx}; gdy = {1'b1, spy_nz};     end
      2'd2: begin gx = '0;    gy = ry;    gdx = {1'b0, spx_nz};    gdy = {lfsr_q[12], spy};  end
      default: begin gx = X_MAX; gy = ry; gdx = {1'b1, spx_nz};    gdy = {lfsr_q[12], spy};  end
    endcase
  end

  // Spawn FSM next state; clear_all aborts any spawn in flight.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    slot_d    = slot_q;
    rr_d      = rr_q;
    count_d   = count_q;
    fail_d    = fail_q;
    ix_d      = ix_q;
    iy_d      = iy_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    if (clear_all) begin
      state_d   = IDLE;
      pending_d = 1'b0;
    end else begin
      if (tick && state_q != IDLE) pending_d = 1'b1;
      case (state_q)
        IDLE: begin
          if ((tick || pending_q) && enable) begin
            state_d   = PICK;
            pending_d = 1'b0;
          end
        end
        PICK: begin
          if (found) begin
            slot_d  = pick;
            ix_d    = gx;
            iy_d    = gy;
            dx_d    = gdx;
            dy_d    = gdy;
            state_d = LAUNCH;
          end else begin
            state_d = IDLE;
          end
        end
        LAUNCH: state_d = CONFIRM;
        CONFIRM: begin
          if (in_use[slot_q]) begin
            if (count_q != 8'hFF) count_d = count_q + 8'd1;
            rr_d = (slot_q == LAST_SLOT) ? '0 : slot_q + PW'(1);
          end else begin
            fail_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Start pulse during LAUNCH, suppressed by clear_all or reset in that cycle.
  always_comb begin
    start = '0;
    if (state_q == LAUNCH && !clear_all && !reset) start = NUM_ROCKS'(1) << slot_q;
    rst_d = clear_all ? '1 : (hit & ~start);
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk60hz) begin
    if (reset) begin
      state_q   <= IDLE;
      timer_q   <= RELOAD;
      pending_q <= 1'b0;
      rr_q      <= '0;
      slot_q    <= '0;
      lfsr_q    <= LFSR_SEED;
      ix_q      <= '0;
      iy_q      <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      count_q   <= '0;
      fail_q    <= 1'b0;
      rst_q     <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      rr_q      <= rr_d;
      slot_q    <= slot_d;
      lfsr_q    <= lfsr_d;
      ix_q      <= ix_d;
      iy_q      <= iy_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      count_q   <= count_d;
      fail_q    <= fail_d;
      rst_q     <= rst_d;
    end
  end

  assign rock_reset  = rst_q;
  assign init_x      = ix_q;
  assign init_y      = iy_q;
  assign dir_x       = dx_q;
  assign dir_y       = dy_q;
  assign spawn_count = count_q;
  assign spawn_fail  = fail_q;

endmodule

// File: tb/tb_rock_spawner.sv
// tb_rock_spawner: directed scenarios followed by randomized traffic, all
// checked each cycle against a schedule-based reference model.
module tb_rock_spawner;

  localparam int N = 8;
  localparam int P = 4;
  localparam int W = 640;
  localparam int H = 480;
  localparam int SEED = 16'hACE1;

  logic       clk60hz = 1'b0;
  logic       reset, enable, clear_all;
  logic [7:0] in_use, hit;
  logic [7:0] start, rock_reset;
  logic [9:0] init_x, init_y;
  logic [2:0] dir_x, dir_y;
  logic [7:0] spawn_count;
  logic       spawn_fail;

  rock_spawner #(
    .NUM_ROCKS(N), .SPAWN_PERIOD(P), .SCREEN_W(W), .SCREEN_H(H), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk60hz(clk60hz), .reset(reset), .enable(enable), .clear_all(clear_all),
    .in_use(in_use), .hit(hit), .start(start), .rock_reset(rock_reset),
    .init_x(init_x), .init_y(init_y), .dir_x(dir_x), .dir_y(dir_y),
    .spawn_count(spawn_count), .spawn_fail(spawn_fail)
  );

  always #5 clk60hz = ~clk60hz;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state
  int m_lfsr, m_timer, m_rr, m_count, m_slot;
  bit m_pending, m_fail;
  logic [7:0] m_rst;
  logic [9:0] m_ix, m_iy;
  logic [2:0] m_dx, m_dy;
  int pick_at, launch_at, confirm_at;

  // Rock-side behaviour and last observed outputs
  bit auto_rock = 1'b1;
  bit rand_rock = 1'b0;
  logic [7:0] e_start, e_rst;
  logic [7:0] obs_start, obs_rr;
  logic [7:0] obs_count;
  logic       obs_fail;
  logic [31:0] obs_all;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_lfsr = SEED; m_timer = P - 1; m_rr = 0; m_count = 0; m_slot = 0;
    m_pending = 0; m_fail = 0; m_rst = 8'h00;
    m_ix = '0; m_iy = '0; m_dx = '0; m_dy = '0;
    pick_at = -1; launch_at = -1; confirm_at = -1;
  endtask

  // Position and direction from the spawn rules applied to one LFSR value.
  task automatic geometry(input int l);
    int edge_n, r, rx, ry, sx, spx, spy;
    edge_n = l & 3;
    r   = (l >> 2) & 1023;
    rx  = (r >= W) ? ((r - 512) & 1023) : r;
    ry  = (r >= H) ? ((r - 512) & 1023) : r;
    sx  = (l >> 12) & 1;
    spx = (l >> 13) & 3;
    spy = (((l >> 15) & 1) * 2) + (l & 1);
    if (edge_n <= 1) begin
      if (spy == 0) spy = 1;
      m_ix = 10'(rx);
      m_iy = (edge_n == 0) ? 10'd0 : 10'(H - 1);
      m_dx = 3'(sx * 4 + spx);
      m_dy = 3'(((edge_n == 1) ? 4 : 0) + spy);
    end else begin
      if (spx == 0) spx = 1;
      m_ix = (edge_n == 2) ? 10'd0 : 10'(W - 1);
      m_iy = 10'(ry);
      m_dx = 3'(((edge_n == 3) ? 4 : 0) + spx);
      m_dy = 3'(sx * 4 + spy);
    end
  endtask

  task automatic model_advance(input bit en, input bit clr, input bit rst,
                               input logic [7:0] h, input logic [7:0] st);
    bit tick, idle, got;
    int fb, s;
    if (rst) begin
      model_reset();
      return;
    end
    tick = en && (m_timer == 0);
    idle = (pick_at != cyc) && (launch_at != cyc) && (confirm_at != cyc);
    fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
    if (clr) begin
      m_rst = 8'hFF; m_timer = P - 1; m_pending = 0;
      pick_at = -1; launch_at = -1; confirm_at = -1;
    end else begin
      m_rst = h & ~st;
      if (en) m_timer = (m_timer == 0) ? P - 1 : m_timer - 1;
      if (cyc == pick_at) begin
        got = 0;
        for (int k = 0; k < N; k++) begin
          s = (m_rr + k) % N;
          if (!got && !in_use[s]) begin got = 1; m_slot = s; end
        end
        if (got) begin
          geometry(m_lfsr);
          launch_at = cyc + 1; confirm_at = cyc + 2;
        end
      end
      if (cyc == confirm_at) begin
        if (in_use[m_slot]) begin
          if (m_count < 255) m_count++;
          m_rr = (m_slot + 1) % N;
        end else m_fail = 1;
      end
      if (idle) begin
        if ((tick || m_pending) && en) begin pick_at = cyc + 1; m_pending = 0; end
      end else if (tick) m_pending = 1;
    end
    m_lfsr = ((m_lfsr << 1) | fb) & 16'hFFFF;
  endtask

  // One clock cycle: drive, compare against the model, advance, update rocks.
  task automatic step(input bit en, input bit clr, input bit rst, input logic [7:0] h);
    logic [7:0] es, er, kill;
    @(negedge clk60hz);
    enable = en; clear_all = clr; reset = rst; hit = h;
    #1;
    es = (!rst && !clr && launch_at == cyc) ? 8'(1 << m_slot) : 8'h00;
    er = m_rst;
    chk("start", 32'(start), 32'(es));
    chk("rock_reset", 32'(rock_reset), 32'(er));
    chk("init_x", 32'(init_x), 32'(m_ix));
    chk("init_y", 32'(init_y), 32'(m_iy));
    chk("dir_x", 32'(dir_x), 32'(m_dx));
    chk("dir_y", 32'(dir_y), 32'(m_dy));
    chk("spawn_count", 32'(spawn_count), 32'(m_count));
    chk("spawn_fail", 32'(spawn_fail), 32'(m_fail));
    obs_start = start; obs_rr = rock_reset; obs_count = spawn_count; obs_fail = spawn_fail;
    obs_all = {8'(start | rock_reset), spawn_count, 8'(init_x | init_y), 8'({dir_x, dir_y, spawn_fail})};
    model_advance(en, clr, rst, h, es);
    e_start = es; e_rst = er;
    @(posedge clk60hz);
    #1;
    if (rand_rock) begin
      kill = 8'($urandom & $urandom & $urandom);
      in_use = ((in_use & ~e_rst) & ~kill) | (($urandom_range(0, 7) == 0) ? 8'h00 : e_start);
    end else if (auto_rock) begin
      in_use = (in_use & ~e_rst) | e_start;
    end
    cyc++;
  endtask

  task automatic run_until(input int n);
    while (cyc < n) step(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; clear_all = 1'b0; in_use = 8'h00; hit = 8'h00;
    repeat (2) @(posedge clk60hz);
    #1;
    chk("reset_start", 32'(start), 32'h0);
    chk("reset_rock_reset", 32'(rock_reset), 32'h0);
    chk("reset_init", 32'({init_x, init_y, dir_x, dir_y}), 32'h0);
    chk("reset_count_fail", 32'({spawn_count, spawn_fail}), 32'h0);
    model_reset();
    cyc = 0;

    // First two spawns on slots 0 and 1
    run_until(5); step(1, 0, 0, 8'h00); chk("t1_start0", 32'(obs_start), 32'h01);
    run_until(7); step(1, 0, 0, 8'h00); chk("t1_count1", 32'(obs_count), 32'd1);
    run_until(9); step(1, 0, 0, 8'h00); chk("t1_start1", 32'(obs_start), 32'h02);
    run_until(11); step(1, 0, 0, 8'h00); chk("t1_count2", 32'(obs_count), 32'd2);
    run_until(27); step(1, 0, 0, 8'h00); chk("count6", 32'(obs_count), 32'd6);

    // No free slot at rr=6
    in_use = 8'hFF;
    run_until(29); step(1, 0, 0, 8'h00); chk("full_nostart", 32'(obs_start), 32'h00);
    run_until(31); step(1, 0, 0, 8'h00); chk("full_count", 32'(obs_count), 32'd6);

    // Retry picks slot 6, then wrap from rr=7 to slot 0
    in_use = 8'b1011_1111;
    run_until(33); step(1, 0, 0, 8'h00); chk("slot6", 32'(obs_start), 32'h40);
    run_until(35); step(1, 0, 0, 8'h00); chk("count7", 32'(obs_count), 32'd7);
    in_use = 8'b1111_0000;
    run_until(37); step(1, 0, 0, 8'h00); chk("wrap_slot0", 32'(obs_start), 32'h01);
    run_until(39); step(1, 0, 0, 8'h00); chk("count8", 32'(obs_count), 32'd8);

    // Rock never reports in_use: sticky fail, rr unchanged
    in_use = 8'h00; auto_rock = 1'b0;
    run_until(41); step(1, 0, 0, 8'h00); chk("fail_launch", 32'(obs_start), 32'h02);
    run_until(43); step(1, 0, 0, 8'h00); chk("fail_set", 32'(obs_fail), 32'd1);
    chk("fail_count", 32'(obs_count), 32'd8);
    auto_rock = 1'b1;
    run_until(45); step(1, 0, 0, 8'h00); chk("rr_kept", 32'(obs_start), 32'h02);
    run_until(47); step(1, 0, 0, 8'h00); chk("fail_sticky", 32'(obs_fail), 32'd1);
    chk("count9", 32'(obs_count), 32'd9);

    // Kill path and start masking
    step(1, 0, 0, 8'h05);
    step(1, 0, 0, 8'h05); chk("kill_launch", 32'(obs_start), 32'h04);
    chk("kill_05", 32'(obs_rr), 32'h05);
    step(1, 0, 0, 8'h00); chk("kill_masked", 32'(obs_rr), 32'h01);
    step(1, 0, 0, 8'h05);
    step(1, 0, 0, 8'h00); chk("kill_05b", 32'(obs_rr), 32'h05);

    // clear_all during LAUNCH, then reset during CONFIRM
    step(1, 1, 0, 8'h00); chk("clr_nostart", 32'(obs_start), 32'h00);
    chk("clr_one_cycle", 32'(obs_rr), 32'h00);
    step(1, 0, 0, 8'h00); chk("clr_all_ones", 32'(obs_rr), 32'hFF);
    run_until(59); step(1, 0, 0, 8'h00); chk("post_clr_start", 32'(obs_start), 32'h08);
    step(1, 0, 1, 8'h00);
    step(1, 0, 0, 8'h00); chk("midreset_zero", obs_all, 32'h0);

    // Randomized traffic
    rand_rock = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 99) == 0,
           $urandom_range(0, 599) == 0, 8'($urandom & $urandom & $urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
